// File: rtl/code_prefetch.sv
// code_prefetch: two-entry AHB instruction prefetch buffer with miss redirect, drain and error halt.
module code_prefetch #(
    parameter int PREFETCH_EN = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] code_addr_bus,
    output logic [31:0] code_data_bus,
    output logic        code_data_already,
    output logic [31:0] I_HADDR,
    output logic [1:0]  I_HTRANS,
    output logic        I_HWRITE,
    output logic [2:0]  I_HSIZE,
    output logic [2:0]  I_HBUST,
    input  logic [31:0] I_HRDATA,
    input  logic        I_HREADY,
    input  logic [1:0]  I_HRESP,
    output logic        fetch_err
);
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_HALT} state_t;

    state_t      state_q, state_d;
    logic        v0_q, v0_d, v1_q, v1_d;
    logic [29:0] tag0_q, tag0_d, tag1_q, tag1_d;
    logic [31:0] dat0_q, dat0_d, dat1_q, dat1_d;
    logic        dpv_q, dpv_d, dpd_q, dpd_d;
    logic [29:0] dpa_q, dpa_d, nf_q, nf_d, ea_q, ea_d;
    logic [29:0] ha_q, ha_d;
    logic [29:0] ca, ptag0;
    logic [31:0] pdat0;
    logic        hit0, hit1, hit, pending, fresh, miss, issue, acc, ok, err, pv0, pv1;
    logic [1:0]  cnt;
    logic        unused_bits;

    assign ca          = code_addr_bus[31:2];
    assign unused_bits = ^code_addr_bus[1:0];
    assign hit0        = v0_q && tag0_q == ca;
    assign hit1        = v1_q && tag1_q == ca && !hit0;
    assign hit         = hit0 || hit1;
    assign pending     = dpv_q && !dpd_q && dpa_q == ca;
    // an empty buffer already pointed at the core address is not a redirect
    assign fresh       = !v0_q && !v1_q && !dpv_q && nf_q == ca;
    assign miss        = (state_q == S_FETCH || state_q == S_DRAIN) && !hit && !pending && !fresh;

    // buffer contents after this cycle's hit1 pop
    assign pv0   = hit1 ? v1_q : v0_q;
    assign ptag0 = hit1 ? tag1_q : tag0_q;
    assign pdat0 = hit1 ? dat1_q : dat0_q;
    assign pv1   = v1_q && !hit1;

    // the word being served does not count against run-ahead; a free slot must remain for the fetch
    assign cnt   = 2'(pv0) + 2'(pv1) + 2'(dpv_q) - 2'(hit);
    assign issue = state_q == S_FETCH && !miss && !(pv0 && pv1) && cnt < 2'(PREFETCH_EN != 0 ? 2 : 1);
    assign acc   = issue && I_HREADY;
    assign ok    = dpv_q && I_HREADY && !dpd_q && I_HRESP == 2'b00;
    assign err   = dpv_q && I_HREADY && !dpd_q && I_HRESP != 2'b00;

    assign code_data_already = hit;
    assign code_data_bus     = hit0 ? dat0_q : hit1 ? dat1_q : 32'h0;
    assign I_HTRANS          = issue ? 2'b10 : 2'b00;
    assign I_HADDR           = {issue ? nf_q : ha_q, 2'b00};
    assign I_HWRITE          = 1'b0;
    assign I_HSIZE           = 3'b010;
    assign I_HBUST           = 3'b000;
    assign fetch_err         = state_q == S_HALT;

    always_comb begin
        state_d = state_q;
        v0_d    = pv0;
        tag0_d  = ptag0;
        dat0_d  = pdat0;
        v1_d    = pv1;
        tag1_d  = tag1_q;
        dat1_d  = dat1_q;
        dpv_d   = acc || (dpv_q && !I_HREADY);
        dpa_d   = acc ? nf_q : dpa_q;
        dpd_d   = acc ? 1'b0 : dpd_q;
        nf_d    = acc ? nf_q + 30'd1 : nf_q;
        ha_d    = issue ? nf_q : ha_q;
        ea_d    = ea_q;
        if (state_q == S_IDLE) begin
            nf_d    = ca;
            state_d = S_FETCH;
        end else if (state_q == S_HALT) begin
            if (ca != ea_q) begin
                nf_d    = ca;
                state_d = S_FETCH;
            end
        end else if (miss) begin
            v0_d    = 1'b0;
            v1_d    = 1'b0;
            nf_d    = ca;
            dpd_d   = dpd_q || dpv_q;
            state_d = (dpv_q && !I_HREADY) ? S_DRAIN : S_FETCH;
        end else if (state_q == S_DRAIN) begin
            if (!dpv_q || I_HREADY) state_d = S_FETCH;
        end else if (err) begin
            v0_d    = 1'b0;
            v1_d    = 1'b0;
            ea_d    = dpa_q;
            dpd_d   = acc;
            state_d = S_HALT;
        end else if (ok) begin
            if (!pv0) begin
                v0_d   = 1'b1;
                tag0_d = dpa_q;
                dat0_d = I_HRDATA;
            end else if (!pv1) begin
                v1_d   = 1'b1;
                tag1_d = dpa_q;
                dat1_d = I_HRDATA;
            end else begin
                // core stalled on a full buffer: drop the word and refetch it later
                nf_d   = dpa_q;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            v0_q    <= 1'b0;
            v1_q    <= 1'b0;
            tag0_q  <= '0;
            tag1_q  <= '0;
            dat0_q  <= '0;
            dat1_q  <= '0;
            dpv_q   <= 1'b0;
            dpd_q   <= 1'b0;
            dpa_q   <= '0;
            nf_q    <= '0;
            ea_q    <= '0;
            ha_q    <= '0;
        end else begin
            state_q <= state_d;
            v0_q    <= v0_d;
            v1_q    <= v1_d;
            tag0_q  <= tag0_d;
            tag1_q  <= tag1_d;
            dat0_q  <= dat0_d;
            dat1_q  <= dat1_d;
            dpv_q   <= dpv_d;
            dpd_q   <= dpd_d;
            dpa_q   <= dpa_d;
            nf_q    <= nf_d;
            ea_q    <= ea_d;
            ha_q    <= ha_d;
        end
    end
endmodule

// File: tb/tb_code_prefetch.sv
// tb_code_prefetch: directed and randomized checks of code_prefetch against a memory/bus model.
module tb_code_prefetch;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] code_addr_bus = 32'h0;
    logic [31:0] I_HRDATA = 32'h0;
    logic        I_HREADY = 1'b1;
    logic [1:0]  I_HRESP = 2'b00;
    logic [31:0] code_data_bus, I_HADDR;
    logic        code_data_already, I_HWRITE, fetch_err;
    logic [1:0]  I_HTRANS;
    logic [2:0]  I_HSIZE, I_HBUST;

    code_prefetch #(.PREFETCH_EN(1)) dut (
        .clk(clk), .reset(reset), .code_addr_bus(code_addr_bus), .code_data_bus(code_data_bus),
        .code_data_already(code_data_already), .I_HADDR(I_HADDR), .I_HTRANS(I_HTRANS),
        .I_HWRITE(I_HWRITE), .I_HSIZE(I_HSIZE), .I_HBUST(I_HBUST), .I_HRDATA(I_HRDATA),
        .I_HREADY(I_HREADY), .I_HRESP(I_HRESP), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    int          pass = 0, total = 0, cy = 0, wait_n = 0;
    logic [31:0] mk = 32'h0, err_a = 32'h1, wait_a = 32'h1, sda = 32'h0;
    bit          rnd_wait = 1'b0, sdv = 1'b0;
    int          sw = 0;
    logic [1:0]  tr;
    logic [31:0] ha, dt;
    logic        al, fe;
    logic [31:0] acc_q[$];

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[31:2], 2'b00} ^ mk;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass++;
        else $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    endtask

    task automatic drive();
        I_HREADY = !sdv || sw == 0;
        I_HRDATA = sdv ? memf(sda) : 32'h0;
        I_HRESP  = (sdv && sw == 0 && sda == err_a) ? 2'b01 : 2'b00;
    endtask

    task automatic samp();
        tr = I_HTRANS;
        ha = I_HADDR;
        al = code_data_already;
        dt = code_data_bus;
        fe = fetch_err;
    endtask

    task automatic book();
        cy++;
        if (!reset) sdv = 1'b0;
        else if (I_HREADY) begin
            sdv = tr == 2'b10;
            sda = ha;
            sw  = (ha == wait_a) ? wait_n : rnd_wait ? int'($urandom_range(0, 2)) : 0;
            if (sdv) acc_q.push_back(ha);
        end else if (sdv) sw--;
    endtask

    task automatic cyc();
        drive();
        #1 samp();
        if (al) chk("served_data", dt, memf(code_addr_bus));
        else chk("idle_data_zero", dt, 32'h0);
        chk("htrans_legal", 32'(tr == 2'b00 || tr == 2'b10), 32'h1);
        chk("haddr_aligned", 32'(ha[1:0]), 32'h0);
        @(posedge clk);
        #1 book();
    endtask

    task automatic do_reset(input logic [31:0] a);
        reset = 1'b0;
        code_addr_bus = a;
        sdv = 1'b0;
        acc_q.delete();
        cyc();
        chk("rst_htrans", 32'(tr), 32'h0);
        chk("rst_haddr", ha, 32'h0);
        chk("rst_already", 32'(al), 32'h0);
        chk("rst_err", 32'(fe), 32'h0);
        cyc();
        reset = 1'b1;
        cy = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, stall, max_stall, hits;
        logic [31:0] a;

        do_reset(32'h100);
        chk("const_hwrite", 32'(I_HWRITE), 32'h0);
        chk("const_hsize", 32'(I_HSIZE), 32'h2);
        chk("const_hbust", 32'(I_HBUST), 32'h0);
        cyc(); chk("t1_c1_idle", 32'(tr), 32'h0);
        cyc(); chk("t1_c2_trans", 32'(tr), 32'h2); chk("t1_c2_addr", ha, 32'h100);
        cyc(); chk("t1_c3_trans", 32'(tr), 32'h2); chk("t1_c3_addr", ha, 32'h104); chk("t1_c3_already", 32'(al), 32'h0);
        cyc(); chk("t1_c4_already", 32'(al), 32'h1); chk("t1_c4_data", dt, 32'h100);
        chk("t1_c4_trans", 32'(tr), 32'h2); chk("t1_c4_addr", ha, 32'h108);
        cyc(); chk("t1_c5_idle", 32'(tr), 32'h0); chk("t1_c5_hold", ha, 32'h108);

        do_reset(32'h100);
        n = 0;
        do begin cyc(); n++; end while (!al && n < 10);
        chk("t2_first_hit", 32'(al), 32'h1);
        chk("t2_first_hit_cycle", 32'(cy), 32'd4);
        for (int i = 1; i < 16; i++) begin
            code_addr_bus = 32'h100 + 32'(4 * i);
            cyc();
            chk("t2_stream_hit", 32'(al), 32'h1);
            chk("t2_stream_data", dt, code_addr_bus);
        end
        chk("t2_issue_count", 32'(acc_q.size() >= 16), 32'h1);
        for (int i = 0; i < 16 && i < acc_q.size(); i++) chk("t2_issue_seq", acc_q[i], 32'h100 + 32'(4 * i));

        wait_a = 32'h108; wait_n = 2;
        do_reset(32'h100);
        repeat (4) cyc();
        chk("t3_c4_already", 32'(al), 32'h1); chk("t3_c4_addr", ha, 32'h108);
        code_addr_bus = 32'h200;
        cyc(); chk("t3_c5_idle", 32'(tr), 32'h0); chk("t3_c5_already", 32'(al), 32'h0);
        cyc(); chk("t3_c6_idle", 32'(tr), 32'h0);
        cyc(); chk("t3_c7_idle", 32'(tr), 32'h0);
        cyc(); chk("t3_c8_trans", 32'(tr), 32'h2); chk("t3_c8_addr", ha, 32'h200);
        cyc();
        cyc(); chk("t3_c10_already", 32'(al), 32'h1); chk("t3_c10_data", dt, 32'h200);
        wait_a = 32'h1; wait_n = 0;

        err_a = 32'h104;
        do_reset(32'h104);
        cyc(); cyc(); chk("t4_c2_addr", ha, 32'h104);
        cyc(); chk("t4_c3_err", 32'(fe), 32'h0);
        for (int i = 4; i < 8; i++) begin
            cyc();
            chk("t4_halt_err", 32'(fe), 32'h1);
            chk("t4_halt_idle", 32'(tr), 32'h0);
            chk("t4_halt_already", 32'(al), 32'h0);
        end
        code_addr_bus = 32'h300;
        cyc(); chk("t4_c8_err", 32'(fe), 32'h1);
        cyc(); chk("t4_c9_err", 32'(fe), 32'h0); chk("t4_c9_trans", 32'(tr), 32'h2); chk("t4_c9_addr", ha, 32'h300);
        cyc(); cyc(); chk("t4_c11_data", dt, 32'h300); chk("t4_c11_already", 32'(al), 32'h1);
        err_a = 32'h1;

        do_reset(32'hFFFF_FFFC);
        cyc(); cyc(); chk("t5_c2_addr", ha, 32'hFFFF_FFFC);
        cyc(); chk("t5_wrap_trans", 32'(tr), 32'h2); chk("t5_wrap_addr", ha, 32'h0);
        cyc(); chk("t5_c4_data", dt, 32'hFFFF_FFFC);

        wait_a = 32'h100; wait_n = 5;
        do_reset(32'h100);
        cyc(); cyc(); chk("t6_c2_addr", ha, 32'h100);
        drive();
        #1 samp();
        chk("t6_pre_trans", 32'(tr), 32'h2); chk("t6_pre_hready", 32'(I_HREADY), 32'h0);
        reset = 1'b0;
        #1 samp();
        chk("t6_rst_trans", 32'(tr), 32'h0); chk("t6_rst_already", 32'(al), 32'h0); chk("t6_rst_addr", ha, 32'h0);
        @(posedge clk);
        #1 book();
        wait_a = 32'h1; wait_n = 0;
        code_addr_bus = 32'h180;
        cyc();
        reset = 1'b1; cy = 0;
        cyc(); cyc(); chk("t6_restart_addr", ha, 32'h180); chk("t6_restart_trans", 32'(tr), 32'h2);
        cyc(); cyc(); chk("t6_restart_data", dt, 32'h180); chk("t6_restart_already", 32'(al), 32'h1);

        mk = $urandom;
        rnd_wait = 1'b1;
        do_reset(32'h400);
        a = 32'h400; stall = 0; max_stall = 0; hits = 0;
        for (int i = 0; i < 3000; i++) begin
            code_addr_bus = a | 32'($urandom_range(0, 3));
            cyc();
            if (al) begin
                hits++;
                stall = 0;
                n = int'($urandom_range(0, 9));
                if (n < 7) a = a + 32'h4;
                else if (n == 7) a = 32'h400 + 32'($urandom_range(0, 63) << 2);
            end else begin
                stall++;
                if (stall > max_stall) max_stall = stall;
                if ($urandom_range(0, 15) == 0) a = 32'h400 + 32'($urandom_range(0, 63) << 2);
            end
        end
        chk("rand_max_stall_bounded", 32'(max_stall <= 30), 32'h1);
        chk("rand_enough_hits", 32'(hits > 500), 32'h1);

        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule

// File: doc/code_prefetch.md
CODE_PREFETCH -- requirements
Module: code_prefetch

Interface
REQ-001 Parameter: PREFETCH_EN, default 1, meaning 1 = run ahead up to 2 words, 0 = at most 1 word buffered or in flight.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
REQ-004 code_addr_bus  input  32  core fetch address; bits [1:0] ignored (treated as 00).
REQ-005 code_data_bus  output  32  instruction word for code_addr_bus when code_data_already=1, else 0.
REQ-006 code_data_already  output  1  1 = code_data_bus valid for current code_addr_bus.
REQ-007 I_HADDR  output  32  AHB address, word aligned.
REQ-008 I_HTRANS  output  2  2'b00 IDLE / 2'b10 NONSEQ only.
REQ-009 I_HWRITE, I_HSIZE, I_HBUST  output  1/3/3  constants 0, 3'b010, 3'b000.
REQ-010 I_HRDATA  input  32  read data.
REQ-011 I_HREADY  input  1  transfer complete / bus accepts address.
REQ-012 I_HRESP  input  2  2'b00 OKAY, 2'b01 ERROR.
REQ-013 fetch_err  output  1  1 while in HALT.

Function
REQ-014 Storage: 2 entries {valid, tag[31:2], data}, entry0 = oldest; one data-phase tracker {dp_valid, dp_addr, dp_discard}; fetch pointer nf.
REQ-015 States: IDLE, FETCH, DRAIN, HALT.
REQ-016 hit0 = valid0 & tag0==code_addr; hit1 = valid1 & tag1==code_addr & !hit0.
REQ-017 code_data_already = hit0|hit1; code_data_bus = data of the hit entry (combinational from registers, 0-cycle latency on hit).
REQ-018 On hit1: entry0 dropped, entry1 moves to entry0 at clock edge; a simultaneous enqueue lands in entry1.
REQ-019 pending = dp_valid & !dp_discard & dp_addr==code_addr; miss = !hit0 & !hit1 & !pending, evaluated in FETCH and DRAIN.
REQ-020 Miss (redirect): invalidate both entries, nf<=code_addr, NONSEQ suppressed that cycle; if dp_valid then dp_discard<=1 and state->DRAIN, else stay/go FETCH.
REQ-021 Issue: in FETCH, no miss, occupancy (valid entries + dp_valid) < (PREFETCH_EN ? 2 : 1) -> I_HTRANS=NONSEQ, I_HADDR=nf; else IDLE, I_HADDR holds last value.
REQ-022 Address accepted when NONSEQ & I_HREADY: dp_valid<=1, dp_addr<=nf, dp_discard<=0, nf<=nf+4 (mod 2^32, 0xFFFFFFFC wraps to 0).
REQ-023 Data phase ends when dp_valid & I_HREADY; dp_valid clears unless a new address is accepted the same cycle.
REQ-024 End with OKAY and !dp_discard: enqueue {dp_addr, I_HRDATA} into first free slot.
REQ-025 End with ERROR and !dp_discard: word dropped, entries invalidated, state->HALT, err_addr<=dp_addr.
REQ-026 Any data phase ending with dp_discard=1: data dropped, no enqueue.
REQ-027 DRAIN: I_HTRANS=IDLE; on discarded data-phase end -> FETCH with empty buffer; further misses in DRAIN only update nf.
REQ-028 HALT: I_HTRANS=IDLE, fetch_err=1; code_addr != err_addr -> nf<=code_addr, FETCH.
REQ-029 IDLE: first cycle after reset release, nf<=code_addr, no issue; -> FETCH.
REQ-030 Latency, zero-wait memory, empty bus: miss cycle N, NONSEQ in N+1, data phase N+2, code_data_already=1 in N+3.
REQ-031 Sequential stream, zero-wait, PREFETCH_EN=1: core advancing +4 per cycle after first hit sees code_data_already=1 every cycle.

Reset
REQ-032 reset=0 asynchronously forces: state IDLE, entries invalid, dp_valid 0, dp_discard 0, nf 0, I_HADDR 0, I_HTRANS 2'b00, code_data_bus 0, code_data_already 0, fetch_err 0.
REQ-033 Reset mid-transfer abandons the outstanding data phase; no data from it is ever enqueued after release.

Verification
REQ-034 Reset release, code_addr=0x100, zero-wait memory returning addr-as-data -> NONSEQ 0x100 in cycle 2, already=1 with data 0x100 in cycle 4, then NONSEQ 0x104, 0x108 prefetched.
REQ-035 Stream 0x100..0x13C, core advances each cycle already=1 -> already=1 every cycle after first hit, no duplicate or skipped HADDR.
REQ-036 Jump to 0x200 while data phase for 0x108 outstanding with HREADY=0 two cycles -> 0x108 data discarded, DRAIN, then NONSEQ 0x200, data 0x200 served.
REQ-037 HRESP=ERROR on 0x104 -> fetch_err=1, HTRANS IDLE while code_addr=0x104; code_addr->0x300 -> fetch_err=0, NONSEQ 0x300.
REQ-038 code_addr=0xFFFFFFFC stream -> next NONSEQ address 0x00000000.
REQ-039 Assert reset while HTRANS=NONSEQ and HREADY=0 -> HTRANS=IDLE and already=0 in the same cycle; after release, fetch restarts from current code_addr.
